// File: rtl/svc_soc_uart_rx_pkg.sv
// Shared types and register map for the UART receiver peripheral.
// Latency: n/a (declarations only).
// Backpressure: n/a. SVC_SOC_UART_RX_PARITY_EN selects 8E1 framing in the users of this package.
package svc_soc_uart_rx_pkg;

  // Receive FSM states; PARITY is only reachable in the 8E1 build
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  // Register offsets from BASE_ADDR
  localparam logic [31:0] REG_DATA_OFS   = 32'h0;
  localparam logic [31:0] REG_STATUS_OFS = 32'h4;

  // STATUS bit positions
  localparam int STAT_NOT_EMPTY  = 0;
  localparam int STAT_FULL       = 1;
  localparam int STAT_OVERRUN    = 2;
  localparam int STAT_FRAME_ERR  = 3;
  localparam int STAT_PARITY_ERR = 4;

  // Even-parity bit that makes the total number of ones even
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/svc_soc_uart_rx_core.sv
// Serial receive core: 2-flop synchroniser, baud counter, frame FSM and shift register.
// Latency: result pulses mid stop bit, 2 sync cycles + CLKS_PER_BIT/2 + 9 (10 with parity) bit-times after the start edge.
// Backpressure: none; byte_valid/frame_err/parity_err are single-cycle pulses. SVC_SOC_UART_RX_PARITY_EN adds an even parity bit.
module svc_soc_uart_rx_core
  import svc_soc_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       urx_pin,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync_q;
  logic          rx_sync;
  logic          rx_prev;
  rx_state_t     state;
  rx_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bad;

  assign rx_sync   = sync_q[1];
  assign byte_data = shreg;

  // Bring the asynchronous pin into the clock domain; keep the previous value for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], urx_pin};
      rx_prev <= sync_q[1];
    end
  end

  // Sample strobe: half a bit into START, a full bit in every timed state
  always_comb begin
    tick = 1'b0;
    case (state)
      ST_START:                    tick = (cnt == HALF_M1);
      ST_DATA, ST_PARITY, ST_STOP: tick = (cnt == FULL_M1);
      default:                     tick = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (rx_prev && !rx_sync) state_nxt = ST_START;
      ST_START:     if (tick) state_nxt = rx_sync ? ST_IDLE : ST_DATA;
`ifdef SVC_SOC_UART_RX_PARITY_EN
      ST_DATA:      if (tick && bit_idx == 3'd7) state_nxt = ST_PARITY;
`else
      ST_DATA:      if (tick && bit_idx == 3'd7) state_nxt = ST_STOP;
`endif
      ST_PARITY:    if (tick) state_nxt = ST_STOP;
      ST_STOP:      if (tick) state_nxt = rx_sync ? ST_IDLE : ST_WAIT_IDLE;
      // A held-low line (break) must go high before another start can be seen
      ST_WAIT_IDLE: if (rx_sync) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Baud counter reloads on state entry and after each sample; bit counter and shift register capture data bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      if (state_nxt != state || tick || state == ST_IDLE || state == ST_WAIT_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      if (state == ST_START)
        bit_idx <= 3'd0;
      else if (state == ST_DATA && tick)
        bit_idx <= bit_idx + 3'd1;
      if (state == ST_DATA && tick)
        shreg <= {rx_sync, shreg[7:1]};
    end
  end

`ifdef SVC_SOC_UART_RX_PARITY_EN
  // Remember a parity mismatch so the stop check can drop the byte
  always_ff @(posedge clk) begin
    if (!rst_n)
      par_bad <= 1'b0;
    else if (state == ST_START)
      par_bad <= 1'b0;
    else if (state == ST_PARITY && tick)
      par_bad <= (rx_sync != even_parity(shreg));
  end
`else
  assign par_bad = 1'b0;
`endif

  // FSM outputs: one-cycle result pulses at the parity and stop samples
  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    if (state == ST_STOP && tick) begin
      byte_valid = rx_sync & ~par_bad;
      frame_err  = ~rx_sync;
    end
`ifdef SVC_SOC_UART_RX_PARITY_EN
    if (state == ST_PARITY && tick)
      parity_err = (rx_sync != even_parity(shreg));
`endif
  end

endmodule

// File: rtl/svc_soc_uart_rx_reg.sv
// Memory-mapped UART receiver: receive core, RX FIFO, sticky error flags and DATA/STATUS read decode.
// Latency: io_rdata is registered, valid the cycle after io_ren.
// Backpressure: none on the line; a byte arriving at a full FIFO is dropped and OVERRUN set. SVC_SOC_UART_RX_PARITY_EN enables 8E1.
module svc_soc_uart_rx_reg
  import svc_soc_uart_rx_pkg::*;
#(
  parameter int          CLOCK_FREQ = 100_000_000,
  parameter int          BAUD_RATE  = 115_200,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0100,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        urx_pin,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  output logic        irq
);

  // CLKS_PER_BIT must be >= 4 and FIFO_DEPTH a power of two >= 2
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CNTW         = AW + 1;

  logic            rx_byte_valid;
  logic [7:0]      rx_byte;
  logic            rx_frame_err;
  logic            rx_parity_err;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            fifo_empty;
  logic            fifo_full;

  logic            sel_data;
  logic            sel_stat;
  logic            push;
  logic            pop;
  logic            ovr_evt;
  logic            ovr_flag;
  logic            ferr_flag;
  logic            perr_flag;
  logic [31:0]     status;

  svc_soc_uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .urx_pin    (urx_pin),
    .byte_valid (rx_byte_valid),
    .byte_data  (rx_byte),
    .frame_err  (rx_frame_err),
    .parity_err (rx_parity_err)
  );

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNTW'(FIFO_DEPTH));
  assign irq        = ~fifo_empty;

  assign sel_data = io_ren && (io_raddr == BASE_ADDR + REG_DATA_OFS);
  assign sel_stat = io_ren && (io_raddr == BASE_ADDR + REG_STATUS_OFS);

  // A pop in the same cycle frees the slot, so push on full still succeeds then
  assign pop     = sel_data & ~fifo_empty;
  assign push    = rx_byte_valid & (~fifo_full | pop);
  assign ovr_evt = rx_byte_valid & fifo_full & ~pop;

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNTW'(push) - CNTW'(pop);
    end
  end

  // FIFO storage; contents are don't-care once the pointers reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  // Sticky error flags clear on a STATUS read; a simultaneous event keeps the bit set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovr_flag  <= 1'b0;
      ferr_flag <= 1'b0;
      perr_flag <= 1'b0;
    end else begin
      ovr_flag  <= (ovr_flag  & ~sel_stat) | ovr_evt;
      ferr_flag <= (ferr_flag & ~sel_stat) | rx_frame_err;
      perr_flag <= (perr_flag & ~sel_stat) | rx_parity_err;
    end
  end

  // STATUS word assembly
  always_comb begin
    status                  = '0;
    status[STAT_NOT_EMPTY]  = ~fifo_empty;
    status[STAT_FULL]       = fifo_full;
    status[STAT_OVERRUN]    = ovr_flag;
    status[STAT_FRAME_ERR]  = ferr_flag;
    status[STAT_PARITY_ERR] = perr_flag;
  end

  // Registered read data; undecoded addresses and idle cycles return zero
  always_ff @(posedge clk) begin
    if (!rst_n)
      io_rdata <= '0;
    else if (sel_data)
      io_rdata <= fifo_empty ? 32'h0 : {23'b0, 1'b1, mem[rd_ptr]};
    else if (sel_stat)
      io_rdata <= status;
    else
      io_rdata <= '0;
  end

endmodule

// File: tb/tb_svc_soc_uart_rx_reg.sv
module tb_svc_soc_uart_rx_reg;

  localparam int          CLOCK_FREQ = 1_600_000;
  localparam int          BAUD_RATE  = 100_000;
  localparam int          CPB        = CLOCK_FREQ / BAUD_RATE;
  localparam logic [31:0] BASE       = 32'h8000_0100;
  localparam logic [31:0] STAT       = 32'h8000_0104;
  localparam int          DEPTH      = 8;
`ifdef SVC_SOC_UART_RX_PARITY_EN
  localparam int          PAR        = 1;
`else
  localparam int          PAR        = 0;
`endif
  // Clock edge (counted from the edge that starts the frame) at which the stop-bit result lands
  localparam int          PUSH_EDGE  = 3 + CPB / 2 + (9 + PAR) * CPB;

  localparam int K_GOOD = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;

  logic        clk;
  logic        rst_n;
  logic        urx_pin;
  logic        io_ren;
  logic [31:0] io_raddr;
  logic [31:0] io_rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Reference model: receive queue plus sticky flags
  logic [7:0] mq[$];
  bit         m_ovr;
  bit         m_ferr;
  bit         m_perr;

  typedef struct {
    logic [7:0]  d;
    int          kind;
    logic [31:0] exp_status;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  svc_soc_uart_rx_reg #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .urx_pin  (urx_pin),
    .io_ren   (io_ren),
    .io_raddr (io_raddr),
    .io_rdata (io_rdata),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int ncyc);
    urx_pin = v;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  // One frame: start, 8 data LSB first, [parity], stop (held low stop_low bit-times for a framing error)
  task automatic send_frame(input logic [7:0] d, input int kind, input int stop_low);
    @(posedge clk);
    #1;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef SVC_SOC_UART_RX_PARITY_EN
    drive_bit((kind == K_PERR) ? ~(^d) : (^d), CPB);
`endif
    if (kind == K_FERR) drive_bit(1'b0, CPB * stop_low);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, 2);
  endtask

  task automatic reg_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    io_ren   = 1'b1;
    io_raddr = addr;
    @(negedge clk);
    io_ren   = 1'b0;
    io_raddr = 32'h0;
    data     = io_rdata;
  endtask

  task automatic rd_expect(input string name, input logic [31:0] addr,
                           input logic [31:0] exp, input logic exp_irq);
    logic [31:0] got;
    reg_read(addr, got);
    check(name, got, exp);
    check({name, "_irq"}, {31'b0, irq}, {31'b0, exp_irq});
  endtask

  task automatic model_frame(input logic [7:0] d, input int kind);
    if (kind == K_FERR)          m_ferr = 1'b1;
    else if (kind == K_PERR)     m_perr = 1'b1;
    else if (mq.size() < DEPTH)  mq.push_back(d);
    else                         m_ovr = 1'b1;
  endtask

  task automatic chk_status(input string name);
    logic [31:0] got;
    logic [31:0] exp;
    exp = {27'b0, m_perr, m_ferr, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    reg_read(STAT, got);
    check(name, got, exp);
    check({name, "_irq"}, {31'b0, irq}, {31'b0, (mq.size() != 0)});
  endtask

  task automatic chk_data(input string name);
    logic [31:0] got;
    logic [31:0] exp;
    exp = (mq.size() != 0) ? {23'b0, 1'b1, mq.pop_front()} : 32'h0;
    reg_read(BASE, got);
    check(name, got, exp);
    check({name, "_irq"}, {31'b0, irq}, {31'b0, (mq.size() != 0)});
  endtask

  initial begin
    logic [7:0]  a5;
    logic [7:0]  rb;
    logic [31:0] oaddr;
    int          r;

    vecs[0] = '{8'h41, K_GOOD, 32'h1, 32'h141};
    vecs[1] = '{8'h00, K_GOOD, 32'h1, 32'h100};
    vecs[2] = '{8'hFF, K_GOOD, 32'h1, 32'h1FF};
    vecs[3] = '{8'h55, K_FERR, 32'h8, 32'h000};
    vecs[4] = '{8'hA5, K_GOOD, 32'h1, 32'h1A5};
    vecs[5] = '{8'h80, K_GOOD, 32'h1, 32'h180};

    rst_n    = 1'b0;
    urx_pin  = 1'b1;
    io_ren   = 1'b0;
    io_raddr = 32'h0;
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_rdata", io_rdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    rd_expect("reset_status", STAT, 32'h0, 1'b0);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].d, vecs[i].kind, 1);
      rd_expect($sformatf("vec%0d_status", i), STAT, vecs[i].exp_status, vecs[i].exp_status[0]);
      rd_expect($sformatf("vec%0d_data", i), BASE, vecs[i].exp_data, 1'b0);
    end

    // 'A' then status clears once drained
    send_frame(8'h41, K_GOOD, 0);
    rd_expect("a_status", STAT, 32'h1, 1'b1);
    rd_expect("a_data", BASE, 32'h141, 1'b0);
    rd_expect("a_status2", STAT, 32'h0, 1'b0);

    // Nine bytes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) send_frame(8'(i), K_GOOD, 0);
    rd_expect("ovr_status", STAT, 32'h7, 1'b1);
    rd_expect("other_addr", BASE + 32'h8, 32'h0, 1'b1);
    rd_expect("zero_addr", 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++)
      rd_expect($sformatf("ovr_data%0d", i), BASE, 32'h100 + 32'(i), (i < 7));
    rd_expect("ovr_lost", BASE, 32'h0, 1'b0);
    rd_expect("ovr_status2", STAT, 32'h0, 1'b0);

    // Break: stop held low three bit-times, then a clean frame
    send_frame(8'h55, K_FERR, 3);
    rd_expect("brk_status", STAT, 32'h8, 1'b0);
    rd_expect("brk_data", BASE, 32'h0, 1'b0);
    send_frame(8'h12, K_GOOD, 0);
    rd_expect("brk_next", BASE, 32'h112, 1'b0);

    // Short low glitch on an idle line
    @(posedge clk);
    #1;
    drive_bit(1'b0, CPB / 4);
    drive_bit(1'b1, 3 * CPB);
    rd_expect("glitch_status", STAT, 32'h0, 1'b0);
    rd_expect("glitch_data", BASE, 32'h0, 1'b0);
    send_frame(8'h6E, K_GOOD, 0);
    rd_expect("glitch_next", BASE, 32'h16E, 1'b0);

`ifdef SVC_SOC_UART_RX_PARITY_EN
    send_frame(8'h03, K_PERR, 0);
    rd_expect("par_bad_status", STAT, 32'h10, 1'b0);
    rd_expect("par_bad_data", BASE, 32'h0, 1'b0);
    send_frame(8'h03, K_GOOD, 0);
    rd_expect("par_ok_data", BASE, 32'h103, 1'b0);
`endif

    // Reset in the middle of a frame after a stored byte and a framing error
    send_frame(8'h99, K_GOOD, 0);
    send_frame(8'hEE, K_FERR, 1);
    a5 = 8'hA5;
    @(posedge clk);
    #1;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(a5[i], CPB);
    drive_bit(a5[3], CPB / 2);
    rst_n   = 1'b0;
    urx_pin = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_expect("rst_status", STAT, 32'h0, 1'b0);
    send_frame(8'h3C, K_GOOD, 0);
    rd_expect("rst_data", BASE, 32'h13C, 1'b0);
    rd_expect("rst_data2", BASE, 32'h0, 1'b0);

    // Push and pop on the same edge with the FIFO full
    mq.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'(32'h20 + i), K_GOOD, 0);
      model_frame(8'(32'h20 + i), K_GOOD);
    end
    fork
      send_frame(8'h77, K_GOOD, 0);
      begin
        @(posedge clk);
        repeat (PUSH_EDGE - 1) @(posedge clk);
        chk_data("full_pushpop_data");
      end
    join
    model_frame(8'h77, K_GOOD);
    chk_status("full_pushpop_status");
    for (int i = 0; i <= DEPTH; i++) chk_data($sformatf("full_drain%0d", i));

    // Framing error landing on the STATUS read edge stays set
    fork
      send_frame(8'h5A, K_FERR, 1);
      begin
        @(posedge clk);
        repeat (PUSH_EDGE - 1) @(posedge clk);
        chk_status("race_status");
      end
    join
    model_frame(8'h5A, K_FERR);
    chk_status("race_status2");

    // Randomised traffic against the model
    for (int n = 0; n < 60; n++) begin
      r  = int'($urandom_range(0, 9));
      rb = 8'($urandom);
      if (r <= 3) begin
        send_frame(rb, K_GOOD, 0);
        model_frame(rb, K_GOOD);
      end else if (r == 4) begin
        send_frame(rb, K_FERR, 1 + int'($urandom_range(0, 1)));
        model_frame(rb, K_FERR);
      end else if (r == 5) begin
`ifdef SVC_SOC_UART_RX_PARITY_EN
        send_frame(rb, K_PERR, 0);
        model_frame(rb, K_PERR);
`else
        send_frame(rb, K_GOOD, 0);
        model_frame(rb, K_GOOD);
`endif
      end else if (r <= 7) begin
        chk_data($sformatf("rand%0d_data", n));
      end else if (r == 8) begin
        chk_status($sformatf("rand%0d_status", n));
      end else begin
        oaddr = BASE + 32'h8 + 32'($urandom_range(0, 15)) * 32'h4;
        rd_expect($sformatf("rand%0d_other", n), oaddr, 32'h0, (mq.size() != 0));
      end
    end
    chk_status("rand_final_status");
    for (int i = 0; i <= DEPTH; i++) chk_data($sformatf("rand_drain%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
